gray_ptr_sync: RTL and testbench

- Receive-side stage for a Gray-coded pointer or counter produced in a foreign clock domain.
- Synchronises the Gray word into the local clock, decodes it to binary and detects each advance.
- Reports the binary value, the step size since the last update, and flags illegal multi-bit Gray transitions.
- Typical use: reading an async-FIFO write/read pointer, or a remote event counter, into the local domain.

---
 rtl/gray_ptr_sync_pkg.sv | 24 ++
 rtl/gray_ptr_sync_if.sv | 23 ++
 rtl/gray_ptr_sync_gray2bin.sv | 12 +
 rtl/gray_ptr_sync.sv | 118 +++++++++++
 tb/tb_gray_ptr_sync.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_ptr_sync_pkg.sv
// Shared types and helpers for the Gray pointer receive stage.
package gray_ptr_sync_pkg;

    localparam logic ST_FILL = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        FILL = ST_FILL,
        RUN  = ST_RUN
    } state_t;

    // Widest vector popcount accepts; callers zero-extend narrower words.
    localparam int unsigned POPCNT_W = 256;

    function automatic int unsigned popcount(input logic [POPCNT_W-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < POPCNT_W; i++) begin
            cnt += {31'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_ptr_sync_if.sv
// Bundle between the pointer consumer and the Gray pointer receive stage.
interface gray_ptr_sync_if #(
    parameter int N = 8
);
    logic [N-1:0] gray_in;
    logic         err_clr;
    logic         ready;
    logic [N-1:0] gray_sync;
    logic [N-1:0] bin_out;
    logic         chg;
    logic [N-1:0] delta;
    logic         err;

    modport master (
        output gray_in, err_clr,
        input  ready, gray_sync, bin_out, chg, delta, err
    );

    modport slave (
        input  gray_in, err_clr,
        output ready, gray_sync, bin_out, chg, delta, err
    );
endinterface

// File: rtl/gray_ptr_sync_gray2bin.sv
// Combinational Gray-to-binary decoder.
module gray2bin #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_gray,
    output logic [N-1:0] o_bin
);
    // b[i] = b[i+1] ^ g[i] unrolls to the XOR of all Gray bits at or above i.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[N-1:i];
    end
endmodule

// File: rtl/gray_ptr_sync.sv
// Brings a foreign-domain Gray pointer into clk, decodes it, and reports each
// advance with its step size and a sticky flag for illegal multi-bit steps.
import gray_ptr_sync_pkg::*;

module gray_ptr_sync #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            rst,
    gray_ptr_sync_if.slave ptr_if
);
    localparam int CNT_W = $clog2(SYNC_STAGES + 1);

    logic [N-1:0]     r_sync [SYNC_STAGES];
    logic [N-1:0]     w_gray_sync;
    logic [N-1:0]     w_bin_dec;
    logic [N-1:0]     w_diff;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [N-1:0]     r_gray_prev, w_gray_prev_nxt;
    logic [N-1:0]     r_bin, w_bin_nxt;
    logic [N-1:0]     r_delta, w_delta_nxt;
    logic             r_chg, w_chg_nxt;
    logic             r_err, w_err_nxt;
    logic             r_ready, w_ready_nxt;

    // NOTE: the synchroniser flops are reset so gray_sync reads 0 in reset like every other output.
    for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
        if (s == 0) begin : g_first
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sync[s] <= '0;
                else     r_sync[s] <= ptr_if.gray_in;
            end
        end else begin : g_next
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sync[s] <= '0;
                else     r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_gray_sync = r_sync[SYNC_STAGES-1];
    assign w_diff      = w_gray_sync ^ r_gray_prev;

    gray2bin #(.N(N)) u_gray2bin (
        .i_gray (w_gray_sync),
        .o_bin  (w_bin_dec)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_gray_prev_nxt = r_gray_prev;
        w_bin_nxt       = r_bin;
        w_delta_nxt     = r_delta;
        w_chg_nxt       = 1'b0;
        w_ready_nxt     = r_ready;
        w_err_nxt       = r_err & ~ptr_if.err_clr;

        case (r_state)
            FILL: begin
                if (r_cnt == CNT_W'(SYNC_STAGES)) begin
                    w_gray_prev_nxt = w_gray_sync;
                    w_bin_nxt       = w_bin_dec;
                    w_ready_nxt     = 1'b1;
                    w_state_nxt     = RUN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (|w_diff) begin
                    w_gray_prev_nxt = w_gray_sync;
                    w_bin_nxt       = w_bin_dec;
                    w_delta_nxt     = w_bin_dec - r_bin;
                    w_chg_nxt       = 1'b1;
                    // A new error overrides a simultaneous clear.
                    if (popcount(POPCNT_W'(w_diff)) > 1) w_err_nxt = 1'b1;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FILL;
            r_cnt       <= '0;
            r_gray_prev <= '0;
            r_bin       <= '0;
            r_delta     <= '0;
            r_chg       <= 1'b0;
            r_err       <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gray_prev <= w_gray_prev_nxt;
            r_bin       <= w_bin_nxt;
            r_delta     <= w_delta_nxt;
            r_chg       <= w_chg_nxt;
            r_err       <= w_err_nxt;
            r_ready     <= w_ready_nxt;
        end
    end

    assign ptr_if.ready     = r_ready;
    assign ptr_if.gray_sync = w_gray_sync;
    assign ptr_if.bin_out   = r_bin;
    assign ptr_if.chg       = r_chg;
    assign ptr_if.delta     = r_delta;
    assign ptr_if.err       = r_err;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Scoreboard bench for gray_ptr_sync: the driver queues expected updates, a
// negedge monitor pops and compares them whenever chg pulses.
module tb_gray_ptr_sync;
    localparam int N           = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FILL_EDGES  = SYNC_STAGES + 1;
    localparam int CHG_LAT     = SYNC_STAGES + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    gray_ptr_sync_if #(.N(N)) bus ();

    gray_ptr_sync #(.N(N), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk    (clk),
        .rst    (rst),
        .ptr_if (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] bin;
        logic [N-1:0] delta;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] m_gray = '0;
    logic [N-1:0] m_bin  = '0;
    logic         m_err  = 1'b0;

    function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Inverse by search: the binary value whose Gray code matches.
    function automatic logic [N-1:0] from_gray(input logic [N-1:0] g);
        for (int v = 0; v < (1 << N); v++) begin
            if (to_gray(N'(v)) == g) return N'(v);
        end
        return '0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [N-1:0] g);
        exp_t e;
        bus.gray_in = g;
        if (g != m_gray) begin
            e.bin   = from_gray(g);
            e.delta = e.bin - m_bin;
            e.err   = m_err || ($countones(g ^ m_gray) > 1);
            e.cyc   = cyc + CHG_LAT;
            sb.push_back(e);
            m_gray = g;
            m_bin  = e.bin;
            m_err  = e.err;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},     32'(bus.ready),     32'd0);
        check({tag, "_bin_out"},   32'(bus.bin_out),   32'd0);
        check({tag, "_chg"},       32'(bus.chg),       32'd0);
        check({tag, "_delta"},     32'(bus.delta),     32'd0);
        check({tag, "_err"},       32'(bus.err),       32'd0);
        check({tag, "_gray_sync"}, 32'(bus.gray_sync), 32'd0);
    endtask

    // Called at a negedge with rst high and gray_in already set.
    task automatic release_rst();
        int  edges;
        logic seen;
        edges = 0;
        seen  = 1'b0;
        rst   = 1'b0;
        while (!seen && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
            seen = bus.ready;
        end
        check("ready_edges",  32'(edges),       32'(FILL_EDGES));
        check("load_bin_out", 32'(bus.bin_out), 32'(from_gray(bus.gray_in)));
        check("load_delta",   32'(bus.delta),   32'd0);
        check("load_err",     32'(bus.err),     32'd0);
        m_gray = bus.gray_in;
        m_bin  = from_gray(bus.gray_in);
        m_err  = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [N-1:0] g);
        check("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        rst         = 1'b1;
        bus.gray_in = g;
        bus.err_clr = 1'b0;
        wait_cyc(2);
        release_rst();
    endtask

    // Monitor: every chg pulse must match the oldest queued update, on time.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.chg === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_chg: got chg=1 bin_out=0x%0h, expected no pulse (t=%0t)",
                             bus.bin_out, $time);
                end else begin
                    e = sb.pop_front();
                    check("chg_cycle", 32'(cyc),       32'(e.cyc));
                    check("chg_bin",   32'(bus.bin_out), 32'(e.bin));
                    check("chg_delta", 32'(bus.delta),   32'(e.delta));
                    check("chg_err",   32'(bus.err),     32'(e.err));
                end
            end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_chg: got no pulse by cycle %0d, expected bin_out=0x%0h at cycle %0d",
                         cyc, e.bin, e.cyc);
            end
        end
    end

    initial begin
        logic [N-1:0] steps [3];
        logic [N-1:0] nxt;
        int           r;
        steps[0] = 8'h01;
        steps[1] = 8'h03;
        steps[2] = 8'h02;

        bus.gray_in = '0;
        bus.err_clr = 1'b0;
        wait_cyc(2);
        check_all_zero("reset");

        // Initial fill from zero.
        release_rst();
        wait_cyc(4);

        // Value held through reset release: gray 0x0C is binary 8.
        do_reset(8'h0C);
        check("hold_bin_out", 32'(bus.bin_out), 32'h08);

        // Single-bit steps, one every 4 clocks.
        do_reset(8'h00);
        foreach (steps[i]) begin
            drive(steps[i]);
            wait_cyc(4);
            check("step_err", 32'(bus.err), 32'd0);
        end
        check("step_final_bin", 32'(bus.bin_out), 32'h03);

        // Wrap 255 -> 0.
        do_reset(8'h80);
        check("wrap_start_bin", 32'(bus.bin_out), 32'hFF);
        drive(8'h00);
        wait_cyc(4);
        check("wrap_bin",   32'(bus.bin_out), 32'h00);
        check("wrap_delta", 32'(bus.delta),   32'h01);
        check("wrap_err",   32'(bus.err),     32'd0);

        // Multi-bit jump, stickiness and clear.
        do_reset(8'h00);
        drive(8'h03);
        wait_cyc(4);
        check("jump_bin",   32'(bus.bin_out), 32'h02);
        check("jump_delta", 32'(bus.delta),   32'h02);
        check("jump_err",   32'(bus.err),     32'd1);
        wait_cyc(6);
        check("jump_err_sticky", 32'(bus.err), 32'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        m_err = 1'b0;
        check("clr_err",   32'(bus.err),     32'd0);
        check("clr_bin",   32'(bus.bin_out), 32'h02);
        check("clr_delta", 32'(bus.delta),   32'h02);

        // Clear coinciding with a newly detected jump: set wins.
        drive(8'h00);
        wait_cyc(2);
        check("coinc_err_before", 32'(bus.err), 32'd0);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("coinc_err_after", 32'(bus.err), 32'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        m_err = 1'b0;
        check("coinc_err_cleared", 32'(bus.err), 32'd0);

        // Randomised walk: mostly legal steps, some holds and arbitrary jumps,
        // with spacing down to back-to-back cycles.
        do_reset(N'($urandom_range(0, 255)));
        repeat (300) begin
            r = $urandom_range(0, 9);
            if (r < 4)      nxt = to_gray(N'(m_bin + 1));
            else if (r < 7) nxt = to_gray(N'(m_bin - 1));
            else if (r < 8) nxt = m_gray;
            else            nxt = N'($urandom_range(0, 255));
            drive(nxt);
            wait_cyc($urandom_range(1, 4));
        end
        wait_cyc(6);

        // Asynchronous reset mid-cycle while tracking.
        do_reset(to_gray(8'h05));
        check("mid_pre_bin",   32'(bus.bin_out), 32'h05);
        check("mid_pre_ready", 32'(bus.ready),   32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        bus.gray_in = N'($urandom_range(0, 255));
        wait_cyc(2);
        release_rst();
        drive(to_gray(N'(m_bin + 1)));
        wait_cyc(5);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
